amb_hakem: RTL

Two-requester arbiter and sequencer in front of the shared amb execution unit. It accepts micro-ops from two issue ports over valid/ready, picks one round-robin, and holds the operation and operands stable on the amb inputs until amb reports a result. It then returns the result, tagged with source and tag, over a valid/ready response channel. It also adds an abort path and a watchdog so a hung multi-cycle operation cannot stall the core.

---
 rtl/amb_hakem_pkg.sv | 12 +
 rtl/hakem_rr2.sv | 24 ++
 rtl/amb_hakem.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/amb_hakem_pkg.sv
// Shared types for the amb front-end arbiter: FSM encodings and default widths.
package amb_hakem_pkg;
  localparam int AMB_VERI_BIT    = 32;
  localparam int UOP_AMB_BIT     = 5;
  localparam int ETIKET_BIT_VARS = 4;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    CALIS = 2'd1,
    YANIT = 2'd2
  } durum_t;
endpackage

// File: rtl/hakem_rr2.sv
// Two-way round-robin grant; combinational grant, last winner updated only on guncelle_i.
// On a tie the port that did not win last time is granted.
module hakem_rr2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] istek_i,
  input  logic       guncelle_i,
  output logic [1:0] grant_o
);
  logic son_kazanan_d, son_kazanan_q;

  always_comb begin
    grant_o[0]    = istek_i[0] & (~istek_i[1] | son_kazanan_q);
    grant_o[1]    = istek_i[1] & (~istek_i[0] | ~son_kazanan_q);
    son_kazanan_d = son_kazanan_q;
    if (guncelle_i) son_kazanan_d = grant_o[1];
  end

  // Reset to port 1 so port 0 takes the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) son_kazanan_q <= 1'b1;
    else       son_kazanan_q <= son_kazanan_d;
  end
endmodule

// File: rtl/amb_hakem.sv
// Arbitrates two micro-op ports onto amb; accept->response in 2 cycles for single-cycle ops.
// Requests stall in CALIS/YANIT; the response is held until sonuc_hazir_i; iptal_i flushes.
module amb_hakem
  import amb_hakem_pkg::*;
#(
  parameter int VERI_BIT    = AMB_VERI_BIT,
  parameter int UOP_BIT     = UOP_AMB_BIT,
  parameter int ETIKET_BIT  = ETIKET_BIT_VARS,
  parameter int ZAMAN_ASIMI = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  istek0_gecerli_i,
  output logic                  istek0_hazir_o,
  input  logic [UOP_BIT-1:0]    istek0_kod_i,
  input  logic [VERI_BIT-1:0]   istek0_islec1_i,
  input  logic [VERI_BIT-1:0]   istek0_islec2_i,
  input  logic [ETIKET_BIT-1:0] istek0_etiket_i,
  input  logic                  istek1_gecerli_i,
  output logic                  istek1_hazir_o,
  input  logic [UOP_BIT-1:0]    istek1_kod_i,
  input  logic [VERI_BIT-1:0]   istek1_islec1_i,
  input  logic [VERI_BIT-1:0]   istek1_islec2_i,
  input  logic [ETIKET_BIT-1:0] istek1_etiket_i,
  output logic [UOP_BIT-1:0]    amb_kod_o,
  output logic                  amb_kod_gecerli_o,
  output logic [VERI_BIT-1:0]   amb_islec1_o,
  output logic [VERI_BIT-1:0]   amb_islec2_o,
  input  logic [VERI_BIT-1:0]   amb_sonuc_i,
  input  logic                  amb_gecerli_i,
  output logic                  sonuc_gecerli_o,
  input  logic                  sonuc_hazir_i,
  output logic [VERI_BIT-1:0]   sonuc_o,
  output logic                  sonuc_kaynak_o,
  output logic [ETIKET_BIT-1:0] sonuc_etiket_o,
  output logic                  sonuc_hata_o,
  input  logic                  iptal_i
);
  localparam int SAYAC_W = $clog2(ZAMAN_ASIMI);
  localparam logic [SAYAC_W-1:0] SAYAC_SON = SAYAC_W'(ZAMAN_ASIMI - 1);

  durum_t                durum_d, durum_q;
  logic [UOP_BIT-1:0]    kod_d, kod_q;
  logic [VERI_BIT-1:0]   islec1_d, islec1_q, islec2_d, islec2_q;
  logic [VERI_BIT-1:0]   sonuc_d, sonuc_q;
  logic [ETIKET_BIT-1:0] etiket_d, etiket_q;
  logic                  kaynak_d, kaynak_q, hata_d, hata_q;
  logic [SAYAC_W-1:0]    sayac_d, sayac_q;
  logic [1:0]            grant;
  logic                  kabul;

  hakem_rr2 u_rr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .istek_i    ({istek1_gecerli_i, istek0_gecerli_i}),
    .guncelle_i (kabul),
    .grant_o    (grant)
  );

  assign istek0_hazir_o    = (durum_q == BOSTA) & ~iptal_i & grant[0];
  assign istek1_hazir_o    = (durum_q == BOSTA) & ~iptal_i & grant[1];
  assign kabul             = istek0_hazir_o | istek1_hazir_o;
  assign amb_kod_gecerli_o = (durum_q == CALIS);
  assign amb_kod_o         = kod_q;
  assign amb_islec1_o      = islec1_q;
  assign amb_islec2_o      = islec2_q;
  assign sonuc_gecerli_o   = (durum_q == YANIT);
  assign sonuc_o           = sonuc_q;
  assign sonuc_kaynak_o    = kaynak_q;
  assign sonuc_etiket_o    = etiket_q;
  assign sonuc_hata_o      = hata_q;

  always_comb begin
    durum_d  = durum_q;
    kod_d    = kod_q;
    islec1_d = islec1_q;
    islec2_d = islec2_q;
    etiket_d = etiket_q;
    kaynak_d = kaynak_q;
    sonuc_d  = sonuc_q;
    hata_d   = hata_q;
    sayac_d  = sayac_q;
    case (durum_q)
      BOSTA: begin
        sayac_d = '0;
        if (kabul) begin
          kod_d    = istek1_hazir_o ? istek1_kod_i    : istek0_kod_i;
          islec1_d = istek1_hazir_o ? istek1_islec1_i : istek0_islec1_i;
          islec2_d = istek1_hazir_o ? istek1_islec2_i : istek0_islec2_i;
          etiket_d = istek1_hazir_o ? istek1_etiket_i : istek0_etiket_i;
          kaynak_d = istek1_hazir_o;
          durum_d  = CALIS;
        end
      end
      CALIS: begin
        // A result arriving on the watchdog's last cycle still counts as success.
        if (amb_gecerli_i) begin
          sonuc_d = amb_sonuc_i;
          hata_d  = 1'b0;
          durum_d = YANIT;
        end else if (sayac_q == SAYAC_SON) begin
          sonuc_d = '0;
          hata_d  = 1'b1;
          durum_d = YANIT;
        end else begin
          sayac_d = sayac_q + SAYAC_W'(1);
        end
      end
      YANIT: begin
        if (sonuc_hazir_i) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
    if (iptal_i) begin
      durum_d = BOSTA;
      sayac_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q  <= BOSTA;
      kod_q    <= '0;
      islec1_q <= '0;
      islec2_q <= '0;
      etiket_q <= '0;
      kaynak_q <= 1'b0;
      sonuc_q  <= '0;
      hata_q   <= 1'b0;
      sayac_q  <= '0;
    end else begin
      durum_q  <= durum_d;
      kod_q    <= kod_d;
      islec1_q <= islec1_d;
      islec2_q <= islec2_d;
      etiket_q <= etiket_d;
      kaynak_q <= kaynak_d;
      sonuc_q  <= sonuc_d;
      hata_q   <= hata_d;
      sayac_q  <= sayac_d;
    end
  end
endmodule
